rtc_core_param: RTL and testbench
=================================

Name: rtc_core_param

Overview:
Parametrised next-generation real-time clock core for the washer/timer subsystem.
- Counts sub-seconds, seconds, minutes and hours from a single system clock.
- Adds run/stop, full time load with validation, 12/24-hour display mode, and a one-shot/sticky alarm.
- Sits behind the AXI register wrapper, which drives the load/alarm strobes and reads the time fields.

Parameters:
CLK_FREQ_HZ, 100_000_000, input clock frequency in Hz.
SUBSEC_HZ, 100, sub-second resolution; o_subsec counts 0..SUBSEC_HZ-1. Constraint: CLK_FREQ_HZ % SUBSEC_HZ == 0 and SUBSEC_HZ <= 256.
FIELD_W, 8, width of every time field port (>= 8).

Ports:
i_clk  in  1  system clock.
i_reset  in  1  synchronous active-high reset.
i_run  in  1  1 = time advances; 0 = frozen (prescaler held).
i_mode12  in  1  1 = o_hour shown as 1..12 with o_pm; 0 = 0..23.
i_load  in  1  one-cycle strobe: load i_ld_hour/min/sec.
i_ld_hour  in  FIELD_W  load value, 0..23.
i_ld_min  in  FIELD_W  load value, 0..59.
i_ld_sec  in  FIELD_W  load value, 0..59.
i_alm_set  in  1  one-cycle strobe: latch i_ld_hour/i_ld_min as alarm time.
i_alm_en  in  1  alarm enable (level).
i_alm_clr  in  1  clear sticky alarm flag.
o_subsec  out  FIELD_W  sub-second count.
o_sec  out  FIELD_W  seconds.
o_min  out  FIELD_W  minutes.
o_hour  out  FIELD_W  hours (format per i_mode12).
o_pm  out  1  PM indicator; 0 when i_mode12=0.
o_sec_tick  out  1  one-cycle pulse on each seconds increment.
o_ld_err  out  1  one-cycle pulse: load or alarm-set rejected (out of range).
o_alarm  out  1  one-cycle pulse on alarm match.
o_alarm_flag  out  1  sticky alarm flag.

Behaviour:
Reset:
- Applied when i_reset=1 at a rising edge.
- Clears all counters, prescaler, alarm time (00:00), alarm flag, and all pulses to 0.
- o_hour reset value follows i_mode12 combinationally: 0 in 24h mode, 12 in 12h mode.
- Reset takes priority over every other input.

Prescaler and sub-seconds:
- DIV = CLK_FREQ_HZ/SUBSEC_HZ.
- The prescaler counts 0..DIV-1 while i_run=1.
- A tick fires in the cycle the prescaler equals DIV-1 with i_run=1. DIV=1 means a tick every cycle.
- Field outputs are registered and update the cycle after the tick.

Carry chain (same edge):
- subsec wraps SUBSEC_HZ-1 -> 0 and carries to sec.
- sec wraps 59 -> 0 and carries to min.
- min wraps 59 -> 0 and carries to hour.
- hour wraps 23 -> 0.
- 23:59:59.(max) -> 00:00:00.0 in one tick.
- o_sec_tick is registered, asserted the same cycle the new o_sec appears.

i_run=0: prescaler and all fields hold; no ticks.

Load:
- Loads are checked in the i_load cycle: hour<=23, min<=59, sec<=59.
- Valid: fields load, subsec=0, prescaler=0, visible next cycle.
- Invalid: no state change, o_ld_err pulses next cycle.
- Load overrides a coincident tick; that tick is lost.

Alarm:
- i_alm_set latches i_ld_hour/i_ld_min under the same range check; invalid pulses o_ld_err.
- If i_load and i_alm_set are asserted in the same cycle, both use the same operands.
- Match is detected when a tick or a valid load produces sec=0, subsec=0, min=alarm min, hour=alarm hour, with i_alm_en=1.
- On match: o_alarm pulses one cycle (aligned with the new field values) and o_alarm_flag sets.
- If i_alm_clr coincides with a new match, set wins.

12h mapping (output only; internal hour is always 0..23):
- 0 -> 12 AM; 1..11 AM; 12 -> 12 PM; 13..23 -> 1..11 PM.

Upper bits of every FIELD_W output above the needed width are 0.

Decomposition:
- Package rtc_pkg holds constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23 and a typedef for the time tuple {hour, min, sec}.
- One natural sub-module: rtc_prescaler, holding the DIV counter, the i_run gate, a sync clear on load, and the tick output.
- Carry chain, load, alarm and 12h mapping live in rtc_core_param.

Test Plan:
1. CLK_FREQ_HZ=1000, SUBSEC_HZ=100 (DIV=10), i_run=1 from reset -> o_subsec=1 after 10 cycles; o_sec=1 and o_sec_tick pulse after 1000 cycles.
2. DIV=1; load 23:59:59, run 100 ticks -> after the wrap tick, fields = 00:00:00.00; o_sec_tick pulses once at the wrap.
3. Load hour=24, min=10, sec=0 -> o_ld_err pulses one cycle later; fields unchanged. Then load min=60 -> same result.
4. i_alm_set with 07:30, i_alm_en=1, load 07:29:59, DIV=1 -> o_alarm pulses when fields become 07:30:00.00; o_alarm_flag stays 1 until i_alm_clr.
5. i_mode12=1 with hours 0, 12 and 13 loaded -> o_hour/o_pm = 12/0, 12/1, 1/1. Reset -> o_hour=12, o_pm=0.
6. i_run=0 for 50 cycles mid-count -> all fields frozen. Assert i_reset during counting -> all outputs clear on the next edge. i_load coincident with a tick -> loaded value wins and subsec=0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants and the time tuple used by the real-time clock core.
package rtc_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } rtc_time_t;

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to one sub-second tick every DIV cycles.
module rtc_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  // With DIV=1 LAST is zero, so the count never moves and tick follows run.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/rtc_core_param.sv
// Real-time clock: carry chain, validated load, alarm and 12/24-hour display.
module rtc_core_param
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SUBSEC_HZ   = 100,
  parameter int unsigned FIELD_W     = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_mode12,
  input  logic               i_load,
  input  logic [FIELD_W-1:0] i_ld_hour,
  input  logic [FIELD_W-1:0] i_ld_min,
  input  logic [FIELD_W-1:0] i_ld_sec,
  input  logic               i_alm_set,
  input  logic               i_alm_en,
  input  logic               i_alm_clr,
  output logic [FIELD_W-1:0] o_subsec,
  output logic [FIELD_W-1:0] o_sec,
  output logic [FIELD_W-1:0] o_min,
  output logic [FIELD_W-1:0] o_hour,
  output logic               o_pm,
  output logic               o_sec_tick,
  output logic               o_ld_err,
  output logic               o_alarm,
  output logic               o_alarm_flag
);

  localparam int unsigned DIV      = CLK_FREQ_HZ / SUBSEC_HZ;
  localparam logic [7:0]  SUB_LAST = 8'(SUBSEC_HZ - 1);

  rtc_time_t  cur_time, nxt_time, ld_time, new_time;
  logic [7:0] subsec, nxt_subsec, new_subsec;
  logic [4:0] alm_hour, hour_disp;
  logic [5:0] alm_min;
  logic       tick, carry_sec, ld_ok, alm_ok, load_ok, advance, update, match;
  logic       sec_tick, ld_err, alarm, alarm_flag, pm;

  rtc_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (i_clk),
    .reset (i_reset),
    .run   (i_run),
    .clear (load_ok),
    .tick  (tick)
  );

  always_comb begin
    ld_time.hour = i_ld_hour[4:0];
    ld_time.min  = i_ld_min[5:0];
    ld_time.sec  = i_ld_sec[5:0];
    alm_ok = (i_ld_hour <= FIELD_W'(HOUR_MAX)) && (i_ld_min <= FIELD_W'(MIN_MAX));
    ld_ok  = alm_ok && (i_ld_sec <= FIELD_W'(SEC_MAX));
  end

  // A load cycle swallows any coincident tick, valid or not.
  assign load_ok = i_load && ld_ok;
  assign advance = tick && !i_load;

  // Full carry chain resolved in a single tick, including midnight wrap.
  always_comb begin
    nxt_time   = cur_time;
    nxt_subsec = subsec + 8'd1;
    carry_sec  = 1'b0;
    if (subsec == SUB_LAST) begin
      nxt_subsec = '0;
      carry_sec  = 1'b1;
      if (cur_time.sec == 6'(SEC_MAX)) begin
        nxt_time.sec = '0;
        if (cur_time.min == 6'(MIN_MAX)) begin
          nxt_time.min  = '0;
          nxt_time.hour = (cur_time.hour == 5'(HOUR_MAX)) ? '0 : cur_time.hour + 5'd1;
        end else begin
          nxt_time.min = cur_time.min + 6'd1;
        end
      end else begin
        nxt_time.sec = cur_time.sec + 6'd1;
      end
    end
  end

  always_comb begin
    new_time   = load_ok ? ld_time : nxt_time;
    new_subsec = load_ok ? 8'd0 : nxt_subsec;
    update     = load_ok || advance;
    match      = update && i_alm_en && (new_subsec == 8'd0) && (new_time.sec == 6'd0) &&
                 (new_time.min == alm_min) && (new_time.hour == alm_hour);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cur_time   <= '0;
      subsec     <= '0;
      alm_hour   <= '0;
      alm_min    <= '0;
      sec_tick   <= 1'b0;
      ld_err     <= 1'b0;
      alarm      <= 1'b0;
      alarm_flag <= 1'b0;
    end else begin
      sec_tick <= advance && carry_sec;
      ld_err   <= (i_load && !ld_ok) || (i_alm_set && !alm_ok);
      alarm    <= match;
      if (update) begin
        cur_time <= new_time;
        subsec   <= new_subsec;
      end
      if (i_alm_set && alm_ok) begin
        alm_hour <= ld_time.hour;
        alm_min  <= ld_time.min;
      end
      if (match) begin
        alarm_flag <= 1'b1;
      end else if (i_alm_clr) begin
        alarm_flag <= 1'b0;
      end
    end
  end

  // Display-only mapping; the stored hour stays 0..23.
  always_comb begin
    hour_disp = cur_time.hour;
    pm        = 1'b0;
    if (i_mode12) begin
      pm = (cur_time.hour >= 5'd12);
      if (cur_time.hour == 5'd0) begin
        hour_disp = 5'd12;
      end else if (cur_time.hour > 5'd12) begin
        hour_disp = cur_time.hour - 5'd12;
      end
    end
  end

  assign o_subsec     = FIELD_W'(subsec);
  assign o_sec        = FIELD_W'(cur_time.sec);
  assign o_min        = FIELD_W'(cur_time.min);
  assign o_hour       = FIELD_W'(hour_disp);
  assign o_pm         = pm;
  assign o_sec_tick   = sec_tick;
  assign o_ld_err     = ld_err;
  assign o_alarm      = alarm;
  assign o_alarm_flag = alarm_flag;

endmodule

// File: tb/tb_rtc_core_param.sv
// Directed bench: one DUT at DIV=10 (a_*) and one at DIV=1 (b_*) sharing inputs.
module tb_rtc_core_param;

  logic       clk, reset, run, mode12, load, alm_set, alm_en, alm_clr;
  logic [7:0] ld_hour, ld_min, ld_sec;

  logic [7:0] a_subsec, a_sec, a_min, a_hour;
  logic       a_pm, a_sec_tick, a_ld_err, a_alarm, a_alarm_flag;
  logic [7:0] b_subsec, b_sec, b_min, b_hour;
  logic       b_pm, b_sec_tick, b_ld_err, b_alarm, b_alarm_flag;

  int errors;
  int checks;

  rtc_core_param #(.CLK_FREQ_HZ(1000), .SUBSEC_HZ(100), .FIELD_W(8)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_mode12(mode12), .i_load(load),
    .i_ld_hour(ld_hour), .i_ld_min(ld_min), .i_ld_sec(ld_sec),
    .i_alm_set(alm_set), .i_alm_en(alm_en), .i_alm_clr(alm_clr),
    .o_subsec(a_subsec), .o_sec(a_sec), .o_min(a_min), .o_hour(a_hour), .o_pm(a_pm),
    .o_sec_tick(a_sec_tick), .o_ld_err(a_ld_err), .o_alarm(a_alarm), .o_alarm_flag(a_alarm_flag)
  );

  rtc_core_param #(.CLK_FREQ_HZ(100), .SUBSEC_HZ(100), .FIELD_W(8)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_mode12(mode12), .i_load(load),
    .i_ld_hour(ld_hour), .i_ld_min(ld_min), .i_ld_sec(ld_sec),
    .i_alm_set(alm_set), .i_alm_en(alm_en), .i_alm_clr(alm_clr),
    .o_subsec(b_subsec), .o_sec(b_sec), .o_min(b_min), .o_hour(b_hour), .o_pm(b_pm),
    .o_sec_tick(b_sec_tick), .o_ld_err(b_ld_err), .o_alarm(b_alarm), .o_alarm_flag(b_alarm_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    ld_hour = h; ld_min = m; ld_sec = s; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    run = 1'b0; reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if ({a_hour, a_min, a_sec, a_subsec, b_hour, b_min, b_sec, b_subsec} !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_fields: got a=%h b=%h expected 0",
                         {a_hour, a_min, a_sec, a_subsec}, {b_hour, b_min, b_sec, b_subsec});
    end
    checks++;
    if ({a_pm, a_sec_tick, a_ld_err, a_alarm, a_alarm_flag, b_pm, b_sec_tick, b_ld_err, b_alarm, b_alarm_flag} !== 10'h0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0",
                         {a_pm, a_sec_tick, a_ld_err, a_alarm, a_alarm_flag, b_pm, b_sec_tick, b_ld_err, b_alarm, b_alarm_flag});
    end
    step(3);
    checks++;
    if ({b_sec, b_subsec} !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_stopped: got %h expected 0000", {b_sec, b_subsec});
    end
  endtask

  task automatic test_prescale;
    run = 1'b1;
    step(9);
    checks++;
    if (a_subsec !== 8'd0) begin errors++; $display("[TB] FAIL pre_9cyc: got %0d expected 0", a_subsec); end
    step(1);
    checks++;
    if (a_subsec !== 8'd1) begin errors++; $display("[TB] FAIL pre_10cyc: got %0d expected 1", a_subsec); end
    step(989);
    checks++;
    if ({a_sec, a_subsec, a_sec_tick} !== {8'd0, 8'd99, 1'b0}) begin
      errors++; $display("[TB] FAIL pre_999cyc: got sec=%0d sub=%0d tick=%b expected 0/99/0", a_sec, a_subsec, a_sec_tick);
    end
    step(1);
    checks++;
    if ({a_sec, a_subsec, a_sec_tick} !== {8'd1, 8'd0, 1'b1}) begin
      errors++; $display("[TB] FAIL pre_1000cyc: got sec=%0d sub=%0d tick=%b expected 1/0/1", a_sec, a_subsec, a_sec_tick);
    end
    step(1);
    checks++;
    if (a_sec_tick !== 1'b0) begin errors++; $display("[TB] FAIL pre_tick_width: got %b expected 0", a_sec_tick); end
  endtask

  task automatic test_wrap;
    int ticks;
    ticks = 0;
    do_load(8'd23, 8'd59, 8'd59);
    checks++;
    if ({b_hour, b_min, b_sec, b_subsec, b_sec_tick} !== {8'd23, 8'd59, 8'd59, 8'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL wrap_load: got %h/%b expected 173b3b00/0", {b_hour, b_min, b_sec, b_subsec}, b_sec_tick);
    end
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (b_sec_tick === 1'b1) ticks++;
      if (i == 99) begin
        checks++;
        if ({b_hour, b_min, b_sec, b_subsec} !== {8'd23, 8'd59, 8'd59, 8'd99}) begin
          errors++; $display("[TB] FAIL wrap_pre: got %h expected 173b3b63", {b_hour, b_min, b_sec, b_subsec});
        end
      end
    end
    checks++;
    if ({b_hour, b_min, b_sec, b_subsec} !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_mid: got %h expected 00000000", {b_hour, b_min, b_sec, b_subsec});
    end
    checks++;
    if (ticks != 1 || b_sec_tick !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_ticks: got count=%0d last=%b expected 1/1", ticks, b_sec_tick);
    end
  endtask

  task automatic test_load_err;
    logic [23:0] bad [3];
    bad = '{{8'd24, 8'd10, 8'd0}, {8'd5, 8'd60, 8'd0}, {8'd5, 8'd6, 8'd60}};
    run = 1'b0;
    do_load(8'd5, 8'd6, 8'd7);
    checks++;
    if ({b_hour, b_min, b_sec, b_subsec, b_ld_err} !== {8'd5, 8'd6, 8'd7, 8'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL load_valid: got %h/%b expected 05060700/0", {b_hour, b_min, b_sec, b_subsec}, b_ld_err);
    end
    for (int i = 0; i < 3; i++) begin
      do_load(bad[i][23:16], bad[i][15:8], bad[i][7:0]);
      checks++;
      if ({b_ld_err, b_hour, b_min, b_sec, b_subsec} !== {1'b1, 8'd5, 8'd6, 8'd7, 8'd0}) begin
        errors++; $display("[TB] FAIL load_bad%0d: got err=%b t=%h expected 1/05060700", i, b_ld_err, {b_hour, b_min, b_sec, b_subsec});
      end
      step(1);
      checks++;
      if (b_ld_err !== 1'b0) begin errors++; $display("[TB] FAIL load_err_width%0d: got %b expected 0", i, b_ld_err); end
    end
  endtask

  task automatic test_alarm;
    run = 1'b0; alm_en = 1'b0;
    ld_hour = 8'd7; ld_min = 8'd60; alm_set = 1'b1;
    step(1);
    alm_set = 1'b0;
    checks++;
    if (b_ld_err !== 1'b1) begin errors++; $display("[TB] FAIL alm_bad: got %b expected 1", b_ld_err); end
    ld_hour = 8'd7; ld_min = 8'd30; alm_set = 1'b1;
    step(1);
    alm_set = 1'b0;
    checks++;
    if (b_ld_err !== 1'b0) begin errors++; $display("[TB] FAIL alm_good: got %b expected 0", b_ld_err); end
    alm_en = 1'b1;
    do_load(8'd7, 8'd29, 8'd59);
    run = 1'b1;
    step(99);
    checks++;
    if ({b_subsec, b_alarm, b_alarm_flag} !== {8'd99, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL alm_before: got sub=%0d alarm=%b flag=%b expected 99/0/0", b_subsec, b_alarm, b_alarm_flag);
    end
    step(1);
    checks++;
    if ({b_hour, b_min, b_sec, b_subsec, b_alarm, b_alarm_flag} !== {8'd7, 8'd30, 8'd0, 8'd0, 1'b1, 1'b1}) begin
      errors++; $display("[TB] FAIL alm_match: got %h alarm=%b flag=%b expected 071e0000/1/1",
                         {b_hour, b_min, b_sec, b_subsec}, b_alarm, b_alarm_flag);
    end
    step(5);
    checks++;
    if ({b_alarm, b_alarm_flag} !== 2'b01) begin
      errors++; $display("[TB] FAIL alm_sticky: got %b expected 01", {b_alarm, b_alarm_flag});
    end
    alm_clr = 1'b1;
    step(1);
    alm_clr = 1'b0;
    checks++;
    if (b_alarm_flag !== 1'b0) begin errors++; $display("[TB] FAIL alm_clear: got %b expected 0", b_alarm_flag); end
    run = 1'b0; alm_clr = 1'b1;
    do_load(8'd7, 8'd30, 8'd0);
    alm_clr = 1'b0;
    checks++;
    if ({b_alarm, b_alarm_flag} !== 2'b11) begin
      errors++; $display("[TB] FAIL alm_set_wins: got %b expected 11", {b_alarm, b_alarm_flag});
    end
    alm_clr = 1'b1;
    step(1);
    alm_clr = 1'b0; alm_en = 1'b0;
  endtask

  task automatic test_mode12;
    logic [7:0] hrs [4];
    logic [8:0] exp12 [4];
    hrs   = '{8'd0, 8'd12, 8'd13, 8'd11};
    exp12 = '{{8'd12, 1'b0}, {8'd12, 1'b1}, {8'd1, 1'b1}, {8'd11, 1'b0}};
    run = 1'b0; mode12 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_load(hrs[i], 8'd0, 8'd0);
      checks++;
      if ({b_hour, b_pm} !== exp12[i]) begin
        errors++; $display("[TB] FAIL mode12_h%0d: got %0d/%b expected %0d/%b", hrs[i], b_hour, b_pm, exp12[i][8:1], exp12[i][0]);
      end
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if ({b_hour, b_pm} !== {8'd12, 1'b0}) begin
      errors++; $display("[TB] FAIL mode12_reset: got %0d/%b expected 12/0", b_hour, b_pm);
    end
    mode12 = 1'b0;
    #1;
    checks++;
    if ({b_hour, b_pm} !== {8'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL mode24_reset: got %0d/%b expected 0/0", b_hour, b_pm);
    end
  endtask

  task automatic test_freeze_and_reset;
    do_load(8'd1, 8'd2, 8'd3);
    run = 1'b1;
    step(30);
    checks++;
    if ({b_hour, b_min, b_sec, b_subsec, a_subsec} !== {8'd1, 8'd2, 8'd3, 8'd30, 8'd3}) begin
      errors++; $display("[TB] FAIL run30: got b=%h a_sub=%0d expected 0102031e/3", {b_hour, b_min, b_sec, b_subsec}, a_subsec);
    end
    run = 1'b0;
    step(50);
    checks++;
    if ({b_hour, b_min, b_sec, b_subsec, a_subsec} !== {8'd1, 8'd2, 8'd3, 8'd30, 8'd3}) begin
      errors++; $display("[TB] FAIL frozen: got b=%h a_sub=%0d expected 0102031e/3", {b_hour, b_min, b_sec, b_subsec}, a_subsec);
    end
    run = 1'b1;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if ({b_hour, b_min, b_sec, b_subsec, a_subsec, a_sec, b_sec_tick, b_alarm_flag} !== 50'h0) begin
      errors++; $display("[TB] FAIL reset_running: got b=%h a=%h expected 0", {b_hour, b_min, b_sec, b_subsec}, {a_sec, a_subsec});
    end
  endtask

  task automatic test_back_to_back;
    step(9);
    checks++;
    if (a_subsec !== 8'd0) begin errors++; $display("[TB] FAIL b2b_pre: got %0d expected 0", a_subsec); end
    do_load(8'd10, 8'd20, 8'd30);
    checks++;
    if ({a_hour, a_min, a_sec, a_subsec, b_hour, b_min, b_sec, b_subsec} !== {8'd10, 8'd20, 8'd30, 8'd0, 8'd10, 8'd20, 8'd30, 8'd0}) begin
      errors++; $display("[TB] FAIL b2b_load_wins: got a=%h b=%h expected 0a141e00", {a_hour, a_min, a_sec, a_subsec}, {b_hour, b_min, b_sec, b_subsec});
    end
    step(5);
    do_load(8'd10, 8'd20, 8'd30);
    step(9);
    checks++;
    if (a_subsec !== 8'd0) begin errors++; $display("[TB] FAIL b2b_clear9: got %0d expected 0", a_subsec); end
    step(1);
    checks++;
    if (a_subsec !== 8'd1) begin errors++; $display("[TB] FAIL b2b_clear10: got %0d expected 1", a_subsec); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b0; run = 1'b0; mode12 = 1'b0; load = 1'b0;
    alm_set = 1'b0; alm_en = 1'b0; alm_clr = 1'b0;
    ld_hour = 8'd0; ld_min = 8'd0; ld_sec = 8'd0;
    test_reset();
    test_prescale();
    test_wrap();
    test_load_err();
    test_alarm();
    test_mode12();
    test_freeze_and_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
